data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder (slave) end of the core's load/store data port: accepts one request at a time over a valid/ready handshake.
- Services the request after a programmable number of wait states from a byte-enabled word array, then returns a response over a second valid/ready handshake.
- Sits between the pipeline's MEM stage initiator and data storage; used to exercise the pipeline against non-zero memory latency.

Parameters:
- DATA_WIDTH, 32, word width in bits (must be 32).
- DEPTH, 128, number of words in the storage array (power of two).
- WAIT_CYCLES, 2, wait states between acceptance and access (0..15).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- req_valid_i, input, 1, initiator has a request.
- req_ready_o, output, 1, responder can accept a request.
- req_write_i, input, 1, 1 = store, 0 = load.
- req_addr_i, input, 32, byte address; bits [1:0] ignored.
- req_wdata_i, input, 32, store data.
- req_be_i, input, 4, byte enables for stores; bit n covers byte n.
- rsp_valid_o, output, 1, response available.
- rsp_ready_i, input, 1, initiator accepts the response.
- rsp_rdata_o, output, 32, load data; 0 for stores.
- rsp_err_o, output, 1, address out of range (see Optional Feature).
- busy_o, output, 1, high whenever the FSM is not IDLE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, busy_o=0, wait counter=0.
- Storage contents are not cleared by reset.
- FSM states and transitions:
  - IDLE: req_ready_o=1. On an edge with req_valid_i=1, capture write/addr/wdata/be and load counter with WAIT_CYCLES. Go to WAIT, or to ACCESS if WAIT_CYCLES==0.
  - WAIT: req_ready_o=0. Decrement the counter each cycle. When the counter reaches 1, go to ACCESS.
  - ACCESS: a single cycle. Stores write the enabled bytes. Loads register the full word into rsp_rdata_o regardless of be. Go to RESP.
  - RESP: rsp_valid_o=1 and data held stable until an edge with rsp_ready_i=1, then go to IDLE.
- Latency: request accepted at edge N gives rsp_valid_o high after edge N+WAIT_CYCLES+1.
- No request is accepted while busy; at most one outstanding transaction.
- req_ready_o returns high in the cycle after the response handshake, so back-to-back requests cost one IDLE cycle.
- Word index = req_addr_i[log2(DEPTH)+1:2]; higher bits wrap modulo DEPTH unless the feature is enabled.
- A store with be=4'b0000 is a no-op write but still produces a response.
- rsp_rdata_o=0 for stores.
- Reset mid-transaction drops the transaction. A store not yet in ACCESS is never committed. No response is issued.
- rsp_ready_i held high before rsp_valid_o rises has no effect until RESP.
- The response inputs are ignored in IDLE/WAIT/ACCESS.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- When defined:
  - Any request with req_addr_i[31:2] >= DEPTH completes with rsp_err_o=1 and rsp_rdata_o=0.
  - The store is suppressed.
  - Timing is unchanged.
- When undefined:
  - rsp_err_o is tied 0.
  - Out-of-range addresses wrap modulo DEPTH.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, ACCESS, RESP);
  - the byte-lane count constant (4);
  - the wait-counter width constant (4).
- One sub-module, dmem_storage_array: DEPTH x 32 array with synchronous byte-enabled write and registered read, driven only in ACCESS.

Test Plan:
- WAIT_CYCLES=2: store 0xDEADBEEF, be=4'hF, to addr 0x10. rsp_valid_o rises 3 edges after acceptance with rdata=0. A following load from 0x10 returns 0xDEADBEEF.
- Partial store: be=4'b0101, wdata=0x11223344, over an existing 0xAABBCCDD. A subsequent load returns 0xAA22CC44.
- Backpressure: hold rsp_ready_i=0 for 5 cycles. rsp_valid_o and rsp_rdata_o stay stable and req_ready_o=0 throughout. Release gives IDLE the next cycle.
- WAIT_CYCLES=0: a load accepted at edge N gives rsp_valid_o after edge N+1. A new req_valid_i during RESP is not accepted.
- Reset asserted in WAIT during a store of 0x55 to addr 0x20. No response appears, and a later load from 0x20 returns the prior value.
- With DMEM_RANGE_CHECK_EN, DEPTH=128: store to 0x200 gives rsp_err_o=1 and word 0 is unchanged. Without the macro, the same store writes word 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

    localparam int BYTE_LANES = 4;
    localparam int CNT_WIDTH  = 4;

endpackage

// File: rtl/dmem_storage_array.sv
// DEPTH x DATA_WIDTH word array with byte-enabled synchronous write and registered read.
module dmem_storage_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTE_LANES-1:0] be,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the read register only moves on a load.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int lane = 0; lane < BYTE_LANES; lane++) begin
                    if (be[lane]) begin
                        mem[idx][lane*8 +: 8] <= wdata[lane*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Load/store responder with programmable wait states in front of a byte-enabled word array.
// Define DMEM_RANGE_CHECK_EN to flag out-of-range addresses instead of wrapping them.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [31:0]           req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BYTE_LANES-1:0] req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t           state;
    dmem_state_t           state_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  accept;

    logic                  cap_write;
    logic [IDX_W-1:0]      cap_idx;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic [BYTE_LANES-1:0] cap_be;
    logic                  range_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign accept = (state == IDLE) && req_valid_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_valid_i) begin
                    cnt_next = CNT_WIDTH'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_next = ACCESS;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_WIDTH'(1);
                if (cnt <= CNT_WIDTH'(1)) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Request fields are held for the whole transaction so the initiator may change them freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_write <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else if (accept) begin
            cap_write <= req_write_i;
            cap_idx   <= req_addr_i[IDX_W+1:2];
            cap_wdata <= req_wdata_i;
            cap_be    <= req_be_i;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic cap_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_err <= 1'b0;
        end else if (accept) begin
            cap_err <= ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH));
        end
    end

    assign range_err = cap_err;
`else
    logic unused_high_addr;

    assign unused_high_addr = ^req_addr_i[31:IDX_W+2];
    assign range_err        = 1'b0;
`endif

    logic unused_low_addr;

    assign unused_low_addr = ^req_addr_i[1:0];

    // A reset landing on the ACCESS edge drops the store along with the transaction.
    assign mem_en = (state == ACCESS) && !reset;
    assign mem_we = cap_write && !range_err;

    dmem_storage_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_storage (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .idx   (cap_idx),
        .wdata (cap_wdata),
        .be    (cap_be),
        .rdata (mem_rdata)
    );

    assign req_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign rsp_valid_o = (state == RESP);
    assign rsp_err_o   = (state == RESP) && range_err;
    assign rsp_rdata_o = ((state == RESP) && !cap_write && !range_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized/directed bench for data_memory_responder against a word-array reference model.
module tb_data_memory_responder;

    localparam int DEPTH = 128;

    logic clk;
    logic reset;

    logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;

    logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    logic [31:0] mdl   [2][DEPTH];
    logic        known [2][DEPTH];

    int vectors;
    int miscompares;

    data_memory_responder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_write_i(a_req_write),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_be_i(a_req_be),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_rdata_o(a_rsp_rdata),
        .rsp_err_o(a_rsp_err), .busy_o(a_busy)
    );

    data_memory_responder #(.DATA_WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_write_i(b_req_write),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_be_i(b_req_be),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata),
        .rsp_err_o(b_rsp_err), .busy_o(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] simulation time limit expired");
    end

    function automatic logic rv(input int sel);
        return (sel == 0) ? a_rsp_valid : b_rsp_valid;
    endfunction

    function automatic logic rq(input int sel);
        return (sel == 0) ? a_req_ready : b_req_ready;
    endfunction

    function automatic logic [31:0] rd(input int sel);
        return (sel == 0) ? a_rsp_rdata : b_rsp_rdata;
    endfunction

    function automatic logic er(input int sel);
        return (sel == 0) ? a_rsp_err : b_rsp_err;
    endfunction

    function automatic logic bz(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    // Out-of-range only matters when the range check is compiled in.
    function automatic logic exp_err(input logic [31:0] addr);
`ifdef DMEM_RANGE_CHECK_EN
        return (addr >> 2) >= 32'(DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input int sel, input logic v, input logic w, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] be);
        if (sel == 0) begin
            a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wdata = wd; a_req_be = be;
        end else begin
            b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wdata = wd; b_req_be = be;
        end
    endtask

    task automatic set_rdy(input int sel, input logic v);
        if (sel == 0) a_rsp_ready = v;
        else          b_rsp_ready = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction: request handshake, latency count, optional backpressure, response handshake.
    task automatic applyStimulus(input int sel, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input int hold, input int wait_cycles);
        logic [31:0] exp_data;
        logic        e;
        int          idx;
        int          k;
        e   = exp_err(addr);
        idx = int'((addr >> 2) % DEPTH);
        exp_data = (!wr && !e) ? mdl[sel][idx] : 32'h0;
        @(negedge clk);
        checkOutput("req_ready before request", 32'(rq(sel)), 32'd1);
        drive(sel, 1'b1, wr, addr, wdata, be);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (wr && !e) begin
            for (int l = 0; l < 4; l++) begin
                if (be[l]) mdl[sel][idx][l*8 +: 8] = wdata[l*8 +: 8];
            end
            if (be == 4'hF) known[sel][idx] = 1'b1;
        end
        k = 0;
        while (!rv(sel) && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("response latency", 32'(k), 32'(wait_cycles + 1));
        @(negedge clk);
        checkOutput("rsp_rdata", rd(sel), exp_data);
        checkOutput("rsp_err", 32'(er(sel)), 32'(e));
        checkOutput("req_ready while busy", 32'(rq(sel)), 32'd0);
        checkOutput("busy while responding", 32'(bz(sel)), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("rsp_valid held", 32'(rv(sel)), 32'd1);
            checkOutput("rsp_rdata held", rd(sel), exp_data);
            checkOutput("req_ready held low", 32'(rq(sel)), 32'd0);
        end
        set_rdy(sel, 1'b1);
        @(posedge clk);
        #1;
        set_rdy(sel, 1'b0);
        checkOutput("rsp_valid after handshake", 32'(rv(sel)), 32'd0);
        checkOutput("req_ready after handshake", 32'(rq(sel)), 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mdl[s][i]   = 32'h0;
                known[s][i] = 1'b0;
            end
        end
        reset = 1'b1;
        a_rsp_ready = 1'b0;
        b_rsp_ready = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("reset req_ready", 32'(rq(s)), 32'd1);
            checkOutput("reset rsp_valid", 32'(rv(s)), 32'd0);
            checkOutput("reset rsp_rdata", rd(s), 32'h0);
            checkOutput("reset rsp_err", 32'(er(s)), 32'd0);
            checkOutput("reset busy", 32'(bz(s)), 32'd0);
        end
        reset = 1'b0;

        $display("[TB] full store then load");
        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 2);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2);

        $display("[TB] partial store over existing word");
        applyStimulus(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'hF, 0, 2);
        applyStimulus(0, 1'b1, 32'h14, 32'h11223344, 4'b0101, 0, 2);
        applyStimulus(0, 1'b0, 32'h17, 32'h0, 4'h0, 0, 2);

        $display("[TB] backpressure and empty byte enables");
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h3, 5, 2);
        applyStimulus(0, 1'b1, 32'h10, 32'h01010101, 4'h0, 1, 2);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 2);

        $display("[TB] reset during wait states drops the store");
        applyStimulus(0, 1'b1, 32'h20, 32'h01020304, 4'hF, 0, 2);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h00000055, 4'hF);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("no response after reset", 32'(a_rsp_valid), 32'd0);
        end
        checkOutput("busy after reset", 32'(a_busy), 32'd0);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 2);

        $display("[TB] address beyond the array");
        applyStimulus(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 2);
        applyStimulus(0, 1'b1, 32'h200, 32'h0BADC0DE, 4'hF, 0, 2);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, 2);
        applyStimulus(0, 1'b0, 32'h200, 32'h0, 4'h0, 0, 2);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) begin
            logic        wr;
            logic [31:0] ad;
            logic [3:0]  be;
            int          ix;
            wr = 1'($urandom_range(0, 1));
            ad = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
            be = 4'($urandom_range(0, 15));
            ix = int'((ad >> 2) % DEPTH);
            if (!exp_err(ad) && !known[0][ix]) begin
                wr = 1'b1;
                be = 4'hF;
            end
            applyStimulus(0, wr, ad, $urandom, be, int'($urandom_range(0, 2)), 2);
        end

        $display("[TB] zero wait states and requests during response");
        applyStimulus(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, 0);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        drive(1, 1'b1, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
        checkOutput("zero-wait not yet valid", 32'(b_rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("zero-wait valid after one edge", 32'(b_rsp_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("request refused during response", 32'(b_req_ready), 32'd0);
            checkOutput("zero-wait load data", b_rsp_rdata, mdl[1][16]);
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        b_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        b_rsp_ready = 1'b0;
        applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
